// File: rtl/line_clear_engine.sv
// line_clear_engine: removes every full row of a falling-block game board,
// collapsing the rows above it downwards, one row examined per SCAN cycle.
// Optional build macro LINE_CLEAR_SCORE_EN adds a saturating 16-bit score
// output that accumulates 0/100/300/500/800 points per completed operation.
module line_clear_engine #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int CNT_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [0:BOARD_W*BOARD_H-1]   boardIn,
    output logic                         busy,
    output logic                         done,
    output logic [0:BOARD_W*BOARD_H-1]   boardOut,
    output logic [CNT_W-1:0]             linesCleared,
    output logic [0:BOARD_H-1]           fullLines,
    output logic                         fullLine
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [15:0]                  score
`endif
);

    localparam int N     = BOARD_W * BOARD_H;
    localparam int PTR_W = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType           stateReg;
    stateType           stateNext;

    logic [0:N-1]       boardReg;
    logic [0:N-1]       collapsed;
    logic [0:BOARD_H-1] rowFull;
    logic [0:BOARD_H-1] inFull;
    logic [0:BOARD_H-1] fullLinesReg;
    logic [CNT_W-1:0]   linesReg;
    logic [PTR_W-1:0]   ptrReg;
    logic               ptrFull;
    logic               loadEn;
    logic               scanLast;

    // Per-row full flags for the working board and for the incoming board,
    // plus the board as it looks after removing the row under the pointer:
    // rows at or above the pointer slide down by one, row 0 refills with zero.
    generate
        for (genvar gi = 0; gi < BOARD_H; gi++) begin : gRow
            assign rowFull[gi] = &boardReg[gi*BOARD_W +: BOARD_W];
            assign inFull[gi]  = &boardIn[gi*BOARD_W +: BOARD_W];
            if (gi == 0) begin : gTop
                assign collapsed[0 +: BOARD_W] = '0;
            end else begin : gBelow
                assign collapsed[gi*BOARD_W +: BOARD_W] =
                    (PTR_W'(gi) <= ptrReg) ? boardReg[(gi-1)*BOARD_W +: BOARD_W]
                                           : boardReg[gi*BOARD_W +: BOARD_W];
            end
        end
    endgenerate

    assign ptrFull  = rowFull[ptrReg];
    // A start is only honoured outside SCAN; during SCAN it is ignored.
    assign loadEn   = start && (stateReg != SCAN);
    // Last SCAN cycle: top row reached and it is not full.
    assign scanLast = (stateReg == SCAN) && !ptrFull && (ptrReg == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state and status decode.
    always_comb begin
        stateNext = stateReg;
        busy      = 1'b0;
        done      = 1'b0;
        case (stateReg)
            IDLE: begin
                if (start) stateNext = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (scanLast) stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = start ? SCAN : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Working board, row pointer, line counter and captured full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boardReg     <= '0;
            fullLinesReg <= '0;
            linesReg     <= '0;
            ptrReg       <= '0;
        end else if (loadEn) begin
            boardReg     <= boardIn;
            fullLinesReg <= inFull;
            linesReg     <= '0;
            ptrReg       <= PTR_W'(BOARD_H - 1);
        end else if (stateReg == SCAN) begin
            if (ptrFull) begin
                // Pointer holds: the row that dropped into place must be re-examined.
                boardReg <= collapsed;
                linesReg <= linesReg + CNT_W'(1);
            end else if (ptrReg != '0) begin
                ptrReg <= ptrReg - PTR_W'(1);
            end
        end
    end

    assign boardOut     = boardReg;
    assign linesCleared = linesReg;
    assign fullLines    = fullLinesReg;
    assign fullLine     = |fullLinesReg;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] scoreReg;
    logic [15:0] scoreAdd;
    logic [16:0] scoreSum;

    // Points awarded for the number of rows removed in the finishing operation.
    always_comb begin
        scoreAdd = 16'd0;
        if (linesReg >= CNT_W'(4)) begin
            scoreAdd = 16'd800;
        end else begin
            case (linesReg)
                CNT_W'(1): scoreAdd = 16'd100;
                CNT_W'(2): scoreAdd = 16'd300;
                CNT_W'(3): scoreAdd = 16'd500;
                default:   scoreAdd = 16'd0;
            endcase
        end
    end

    assign scoreSum = {1'b0, scoreReg} + {1'b0, scoreAdd};

    // Score accumulates on entry to DONE and saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scoreReg <= '0;
        end else if (scanLast) begin
            scoreReg <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
        end
    end

    assign score = scoreReg;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine (BOARD_W=10, BOARD_H=20).
// Score checks are active when LINE_CLEAR_SCORE_EN is defined.
module tb_line_clear_engine;

    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;
    localparam int C = 5;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [0:N-1]   boardIn;
    logic           busy;
    logic           done;
    logic [0:N-1]   boardOut;
    logic [C-1:0]   linesCleared;
    logic [0:H-1]   fullLines;
    logic           fullLine;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]    score;
`endif

    int checks = 0;
    int errors = 0;
    int scoreModel = 0;

    line_clear_engine #(.BOARD_W(W), .BOARD_H(H), .CNT_W(C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .boardIn      (boardIn),
        .busy         (busy),
        .done         (done),
        .boardOut     (boardOut),
        .linesCleared (linesCleared),
        .fullLines    (fullLines),
        .fullLine     (fullLine)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .score        (score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [0:N-1] board;
        logic [0:N-1] expBoard;
        logic [0:H-1] expFull;
        int           expLines;
        int           expCycles;
    } vecT;

    vecT vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int points(input int n);
        if (n >= 4) return 800;
        if (n == 3) return 500;
        if (n == 2) return 300;
        if (n == 1) return 100;
        return 0;
    endfunction

    // Reference: keep non-full rows in order, stack them at the bottom.
    task automatic model(input logic [0:N-1] b, output logic [0:N-1] o,
                         output int n, output logic [0:H-1] fl);
        logic [W-1:0] row;
        int dst;
        o   = '0;
        n   = 0;
        fl  = '0;
        dst = H - 1;
        for (int r = H - 1; r >= 0; r--) begin
            row = b[r*W +: W];
            if (row == {W{1'b1}}) begin
                fl[r] = 1'b1;
                n++;
            end else begin
                o[dst*W +: W] = row;
                dst--;
            end
        end
    endtask

    function automatic logic [0:N-1] randBoard();
        logic [0:N-1] b;
        for (int r = 0; r < H; r++) begin
            if ($urandom_range(0, 2) == 0) b[r*W +: W] = '1;
            else                           b[r*W +: W] = W'($urandom);
        end
        return b;
    endfunction

    // Wait out SCAN counting its cycles; optional noise on start/boardIn.
    task automatic waitScan(input bit noise, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 300) begin
            cycles++;
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                boardIn = randBoard();
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic checkResult(input string nm, input logic [0:N-1] expB,
                               input logic [0:H-1] expFl, input int expN);
        check({nm, " boardOut"}, 256'(boardOut), 256'(expB));
        check({nm, " linesCleared"}, 256'(linesCleared), 256'(expN));
        check({nm, " fullLines"}, 256'(fullLines), 256'(expFl));
        check({nm, " fullLine"}, 256'(fullLine), 256'(|expFl));
    endtask

    task automatic runOp(input string nm, input logic [0:N-1] b, input logic [0:N-1] expB,
                         input logic [0:H-1] expFl, input int expN, input int expCyc,
                         input bit noise);
        int cyc;
        boardIn = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check({nm, " busy after start"}, 256'(busy), 256'(1));
        waitScan(noise, cyc);
        check({nm, " scan cycles"}, 256'(cyc), 256'(expCyc));
        check({nm, " done pulse"}, 256'(done), 256'(1));
        check({nm, " busy in done"}, 256'(busy), 256'(0));
        checkResult(nm, expB, expFl, expN);
        scoreModel = scoreModel + points(expN);
        if (scoreModel > 65535) scoreModel = 65535;
`ifdef LINE_CLEAR_SCORE_EN
        check({nm, " score"}, 256'(score), 256'(scoreModel));
`endif
        $display("op %s: cycles=%0d lines=%0d done=%0b", nm, cyc, linesCleared, done);
        tick();
        check({nm, " done one cycle"}, 256'(done), 256'(0));
        checkResult({nm, " hold"}, expB, expFl, expN);
    endtask

    initial begin
        logic [0:N-1] b;
        logic [0:N-1] e;
        logic [0:H-1] f;
        logic [W-1:0] pat;
        int n;
        int cyc;

        rst_n   = 1'b0;
        start   = 1'b0;
        boardIn = '0;
        pat     = 10'b0101010101;

        // Directed vectors.
        vecs[0].name = "empty";
        vecs[0].board = '0; vecs[0].expBoard = '0; vecs[0].expFull = '0;
        vecs[0].expLines = 0; vecs[0].expCycles = 20;

        b = '0; b[19*W +: W] = '1; b[18*W] = 1'b1;
        e = '0; e[19*W] = 1'b1;
        f = '0; f[19] = 1'b1;
        vecs[1].name = "row19"; vecs[1].board = b; vecs[1].expBoard = e;
        vecs[1].expFull = f; vecs[1].expLines = 1; vecs[1].expCycles = 21;

        b = '0; b[17*W +: W] = '1; b[19*W +: W] = '1; b[18*W +: W] = pat;
        e = '0; e[19*W +: W] = pat;
        f = '0; f[17] = 1'b1; f[19] = 1'b1;
        vecs[2].name = "rows17_19"; vecs[2].board = b; vecs[2].expBoard = e;
        vecs[2].expFull = f; vecs[2].expLines = 2; vecs[2].expCycles = 22;

        b = '0; f = '0;
        for (int r = 16; r < 20; r++) begin b[r*W +: W] = '1; f[r] = 1'b1; end
        vecs[3].name = "rows16_19"; vecs[3].board = b; vecs[3].expBoard = '0;
        vecs[3].expFull = f; vecs[3].expLines = 4; vecs[3].expCycles = 24;

        vecs[4].name = "all_ones"; vecs[4].board = '1; vecs[4].expBoard = '0;
        vecs[4].expFull = '1; vecs[4].expLines = 20; vecs[4].expCycles = 40;

        tick();
        tick();
        check("reset busy", 256'(busy), 256'(0));
        check("reset done", 256'(done), 256'(0));
        checkResult("reset", '0, '0, 0);
`ifdef LINE_CLEAR_SCORE_EN
        check("reset score", 256'(score), 256'(0));
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            runOp(vecs[i].name, vecs[i].board, vecs[i].expBoard, vecs[i].expFull,
                  vecs[i].expLines, vecs[i].expCycles, 1'b0);
        end

        // Start and board changes during SCAN must be ignored.
        runOp("noisy_rows17_19", vecs[2].board, vecs[2].expBoard, vecs[2].expFull,
              2, 22, 1'b1);

        // Start in the DONE cycle launches the next operation immediately.
        boardIn = vecs[1].board;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        waitScan(1'b0, cyc);
        check("chain first cycles", 256'(cyc), 256'(21));
        check("chain first done", 256'(done), 256'(1));
        scoreModel = scoreModel + 100;
        boardIn = vecs[2].board;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("chain restart busy", 256'(busy), 256'(1));
        check("chain restart done", 256'(done), 256'(0));
        check("chain restart fullLines", 256'(fullLines), 256'(vecs[2].expFull));
        check("chain restart lines", 256'(linesCleared), 256'(0));
        waitScan(1'b0, cyc);
        check("chain second cycles", 256'(cyc), 256'(22));
        check("chain second done", 256'(done), 256'(1));
        checkResult("chain second", vecs[2].expBoard, vecs[2].expFull, 2);
        scoreModel = scoreModel + 300;
`ifdef LINE_CLEAR_SCORE_EN
        check("chain score", 256'(score), 256'(scoreModel));
`endif
        $display("op chain: cycles=%0d lines=%0d", cyc, linesCleared);
        tick();

        // Randomized boards against the compaction model.
        for (int t = 0; t < 30; t++) begin
            b = randBoard();
            model(b, e, n, f);
            runOp($sformatf("rand%0d", t), b, e, f, n, H + n, 1'(t % 2));
        end

        // Reset in SCAN cycle 5 aborts immediately, no done pulse; reset beats start.
        boardIn = vecs[3].board;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("abort still busy", 256'(busy), 256'(1));
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("abort busy", 256'(busy), 256'(0));
        check("abort done", 256'(done), 256'(0));
        checkResult("abort", '0, '0, 0);
        scoreModel = 0;
`ifdef LINE_CLEAR_SCORE_EN
        check("abort score", 256'(score), 256'(0));
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            check("reset over start busy", 256'(busy), 256'(0));
            check("reset no done", 256'(done), 256'(0));
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post reset idle", 256'(busy), 256'(0));
        check("post reset no done", 256'(done), 256'(0));
        $display("op abort: busy=%0b done=%0b", busy, done);

        runOp("after_reset", vecs[1].board, vecs[1].expBoard, vecs[1].expFull, 1, 21, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL have parameter BOARD_W, default 10: board columns per row.
REQ-002 SHALL have parameter BOARD_H, default 20: board rows; row 0 is top, row BOARD_H-1 is bottom.
REQ-003 SHALL have parameter CNT_W, default 5: width of line counter; SHALL satisfy 2^CNT_W > BOARD_H.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to process boardIn; sampled when busy=0.
REQ-007 SHALL have port boardIn  input  [0:BOARD_W*BOARD_H-1]  occupancy; row r occupies bits r*BOARD_W to r*BOARD_W+BOARD_W-1.
REQ-008 SHALL have port busy  output  1  high while scanning/collapsing.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port boardOut  output  [0:BOARD_W*BOARD_H-1]  collapsed board, same layout as boardIn.
REQ-011 SHALL have port linesCleared  output  [CNT_W-1:0]  number of rows removed in last operation.
REQ-012 SHALL have port fullLines  output  [0:BOARD_H-1]  per-row full flags of the board captured at start.
REQ-013 SHALL have port fullLine  output  1  OR of fullLines.

Function
REQ-014 SHALL implement states IDLE, SCAN, DONE; busy=1 only in SCAN, done=1 only in DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL load boardIn into the working board (boardOut), capture fullLines from boardIn, clear linesCleared, set row pointer to BOARD_H-1, enter SCAN.
REQ-016 start while in SCAN SHALL be ignored with no effect on any output.
REQ-017 A row SHALL be full iff all BOARD_W bits of that row in the working board are 1.
REQ-018 Each SCAN cycle, if working row[ptr] is full: rows 1..ptr SHALL take the previous contents of rows 0..ptr-1, row 0 SHALL become all zero, linesCleared SHALL increment, ptr SHALL hold.
REQ-019 Each SCAN cycle, if working row[ptr] is not full and ptr>0, ptr SHALL decrement; if ptr=0, next state SHALL be DONE.
REQ-020 SCAN SHALL last exactly BOARD_H+n cycles, n = rows cleared; done SHALL be high in the cycle following the final SCAN cycle.
REQ-021 DONE SHALL last one cycle then go to IDLE unless start=1, which is accepted per REQ-015.
REQ-022 boardOut, linesCleared, fullLines, fullLine SHALL hold stable from DONE until the next accepted start.
REQ-023 Row 0 after a shift is all zero and therefore never full; the engine SHALL terminate for every input, including an all-ones board (n=BOARD_H, board all zero).

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, boardOut=0, linesCleared=0, fullLines=0, fullLine=0, ptr=0.
REQ-025 Reset during SCAN SHALL abort the operation; done SHALL NOT pulse for it.
REQ-026 Reset SHALL dominate start in the same cycle.

Configuration
REQ-027 With macro LINE_CLEAR_SCORE_EN defined, SHALL add output score [15:0], reset 0, incremented on entry to DONE by 0/100/300/500/800 for n=0/1/2/3/>=4, saturating at 16'hFFFF, never cleared except by reset.
REQ-028 Without LINE_CLEAR_SCORE_EN, score port and logic SHALL be absent; all other behaviour identical.

Verification (BOARD_W=10, BOARD_H=20, LINE_CLEAR_SCORE_EN defined)
REQ-029 Empty board, start pulse -> busy 20 cycles, done next cycle, linesCleared=0, boardOut=0, fullLine=0, score unchanged.
REQ-030 Row 19 all ones, row 18 = col 0 only -> 21 SCAN cycles, linesCleared=1, fullLines bit 19 only, boardOut row 19 = col 0 only, rows 0..18 zero, score=100.
REQ-031 Rows 17 and 19 full, row 18 = 10'b0101010101 -> linesCleared=2, row 19 = 10'b0101010101, others zero, score +300.
REQ-032 Rows 16..19 full, rest empty -> linesCleared=4, boardOut=0, 24 SCAN cycles, score +800; all-ones board -> linesCleared=20, boardOut=0, score +800.
REQ-033 rst_n low in SCAN cycle 5 -> all outputs 0 immediately, no done pulse; start during SCAN -> ignored; start in DONE cycle -> new SCAN next cycle.
